// File: rtl/collision_scan_ctrl_pkg.sv
// rtl/collision_scan_ctrl_pkg.sv - shared state encoding, flag indices and coordinate widths
package collision_scan_ctrl_pkg;

    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int FLAG_W = 4;

    localparam int FLAG_DOWN  = 0;
    localparam int FLAG_UP    = 1;
    localparam int FLAG_RIGHT = 2;
    localparam int FLAG_LEFT  = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } scan_state_t;

endpackage

// File: rtl/collision_scan_ctrl_scan_valid_pipe.sv
// rtl/collision_scan_ctrl_scan_valid_pipe.sv - issue-valid / tile_valid alignment pipe
// Tracks each issued address through ROM and checker latency and qualifies it with tile_valid.
module scan_valid_pipe
    import collision_scan_ctrl_pkg::*;
#(
    parameter int ROM_LAT = 1,
    parameter int CHK_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_issue,
    input  logic i_tile_valid,
    output logic o_acc_en,
    output logic o_pending
);

    localparam int DEPTH = ROM_LAT + CHK_LAT;

    logic [DEPTH-1:0]   r_issue;
    logic [CHK_LAT-1:0] r_tile_valid;

    // tile_valid arrives ROM_LAT after issue, so CHK_LAT more stages line it up with r_issue's tail
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue      <= '0;
            r_tile_valid <= '0;
        end else begin
            r_issue[0]      <= i_issue;
            r_tile_valid[0] <= i_tile_valid;
            for (int k = 1; k < DEPTH; k++) begin
                r_issue[k] <= r_issue[k-1];
            end
            for (int k = 1; k < CHK_LAT; k++) begin
                r_tile_valid[k] <= r_tile_valid[k-1];
            end
        end
    end

    assign o_acc_en  = r_issue[DEPTH-1] & r_tile_valid[CHK_LAT-1];
    assign o_pending = |r_issue;

endmodule

// File: rtl/collision_scan_ctrl.sv
// rtl/collision_scan_ctrl.sv - per-frame tile scan sequencer for a shared collision checker
// Streams every ROM tile through the checker and publishes the OR of all valid-tile flags.
module collision_scan_ctrl
    import collision_scan_ctrl_pkg::*;
#(
    parameter int N_TILES = 32,
    parameter int AW      = 5,
    parameter int ROM_LAT = 1,
    parameter int CHK_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [X_W-1:0]    x_blue,
    input  logic [Y_W-1:0]    y_blue,
    output logic [AW-1:0]     tile_addr,
    input  logic [X_W-1:0]    tile_x,
    input  logic [Y_W-1:0]    tile_y,
    input  logic              tile_valid,
    output logic [X_W-1:0]    chk_x_blue,
    output logic [Y_W-1:0]    chk_y_blue,
    output logic [X_W-1:0]    chk_x_ground,
    output logic [Y_W-1:0]    chk_y_ground,
    input  logic [FLAG_W-1:0] chk_flags,
    output logic              busy,
    output logic              done,
    output logic [FLAG_W-1:0] coll_flags
);

    scan_state_t       r_state;
    scan_state_t       w_next_state;
    logic [AW-1:0]     r_tile_addr;
    logic [X_W-1:0]    r_x_blue;
    logic [Y_W-1:0]    r_y_blue;
    logic [FLAG_W-1:0] r_acc;
    logic [FLAG_W-1:0] r_coll_flags;
    logic              w_issue;
    logic              w_busy;
    logic              w_done;
    logic              w_start_scan;
    logic              w_last_addr;
    logic              w_acc_en;
    logic              w_pending;

    assign w_last_addr = (r_tile_addr == AW'(N_TILES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_last_addr) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!w_pending) w_next_state = ST_FINISH;
            end
            ST_FINISH: begin
                w_next_state = start ? ST_ISSUE : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FINISH accepts a new frame tick so scans can run back to back
    always_comb begin
        w_issue      = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_start_scan = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy       = 1'b0;
                w_start_scan = start;
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
            end
            ST_DRAIN: begin
                w_issue = 1'b0;
            end
            ST_FINISH: begin
                w_done       = 1'b1;
                w_start_scan = start;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    scan_valid_pipe #(
        .ROM_LAT (ROM_LAT),
        .CHK_LAT (CHK_LAT)
    ) u_valid_pipe (
        .clk          (clk),
        .rst          (rst),
        .i_issue      (w_issue),
        .i_tile_valid (tile_valid),
        .o_acc_en     (w_acc_en),
        .o_pending    (w_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tile_addr <= '0;
            r_x_blue    <= '0;
            r_y_blue    <= '0;
            r_acc       <= '0;
        end else if (w_start_scan) begin
            r_tile_addr <= '0;
            r_x_blue    <= x_blue;
            r_y_blue    <= y_blue;
            r_acc       <= '0;
        end else begin
            if (w_issue && !w_last_addr) begin
                r_tile_addr <= r_tile_addr + AW'(1);
            end else if (r_state == ST_FINISH) begin
                r_tile_addr <= '0;
            end
            if (w_acc_en) begin
                r_acc <= r_acc | chk_flags;
            end
        end
    end

    // Published word changes only on entry to FINISH, so consumers never see a partial OR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coll_flags <= '0;
        end else if (r_state == ST_DRAIN && w_next_state == ST_FINISH) begin
            r_coll_flags <= r_acc;
        end
    end

    assign tile_addr    = r_tile_addr;
    assign chk_x_blue   = r_x_blue;
    assign chk_y_blue   = r_y_blue;
    assign chk_x_ground = tile_x;
    assign chk_y_ground = tile_y;
    assign busy         = w_busy;
    assign done         = w_done;
    assign coll_flags   = r_coll_flags;

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// tb/tb_collision_scan_ctrl.sv - self-checking bench for collision_scan_ctrl
module tb_collision_scan_ctrl;

    localparam int N  = 4;
    localparam int AW = 2;

    typedef struct {
        logic [N-1:0]   v;
        logic [4*N-1:0] f;
        logic [3:0]     exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic [9:0]  x_blue;
    logic [8:0]  y_blue;
    logic [AW-1:0] tile_addr;
    logic [9:0]  tile_x = '0;
    logic [8:0]  tile_y = '0;
    logic        tile_valid = 1'b0;
    logic [9:0]  chk_x_blue;
    logic [8:0]  chk_y_blue;
    logic [9:0]  chk_x_ground;
    logic [8:0]  chk_y_ground;
    logic [3:0]  chk_flags = '0;
    logic        busy;
    logic        done;
    logic [3:0]  coll_flags;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] last_exp;

    logic [9:0] rom_x [N];
    logic [8:0] rom_y [N];
    logic       rom_v [N];
    logic [3:0] ftab  [N];

    vec_t vecs [7];

    collision_scan_ctrl #(
        .N_TILES (N),
        .AW      (AW),
        .ROM_LAT (1),
        .CHK_LAT (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x_blue       (x_blue),
        .y_blue       (y_blue),
        .tile_addr    (tile_addr),
        .tile_x       (tile_x),
        .tile_y       (tile_y),
        .tile_valid   (tile_valid),
        .chk_x_blue   (chk_x_blue),
        .chk_y_blue   (chk_y_blue),
        .chk_x_ground (chk_x_ground),
        .chk_y_ground (chk_y_ground),
        .chk_flags    (chk_flags),
        .busy         (busy),
        .done         (done),
        .coll_flags   (coll_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lookup(input logic [9:0] gx, input logic [8:0] gy);
        for (int i = 0; i < N; i++) begin
            if (rom_x[i] === gx && rom_y[i] === gy) return ftab[i];
        end
        return 4'b0000;
    endfunction

    function automatic logic [3:0] model_or();
        logic [3:0] acc = 4'b0000;
        for (int i = 0; i < N; i++) begin
            if (rom_v[i]) acc = acc | ftab[i];
        end
        return acc;
    endfunction

    // synchronous tile ROM and registered checker
    always @(posedge clk) begin
        tile_x     <= rom_x[tile_addr];
        tile_y     <= rom_y[tile_addr];
        tile_valid <= rom_v[tile_addr];
        chk_flags  <= lookup(chk_x_ground, chk_y_ground);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [N-1:0] v, input logic [4*N-1:0] f);
        for (int i = 0; i < N; i++) begin
            rom_v[i] = v[i];
            ftab[i]  = f[4*i +: 4];
            rom_x[i] = 10'(i * 200 + $urandom_range(0, 99));
            rom_y[i] = 9'($urandom_range(0, 511));
        end
    endtask

    task automatic run_scan(input logic [3:0] exp, input string nm, input bit detail);
        int cyc;
        start = 1'b1;
        @(negedge clk);
        cyc   = 0;
        start = 1'b0;
        check({nm, "_busy_first"}, busy, 1);
        while (!done && cyc < 40) begin
            if (detail) begin
                check($sformatf("%s_addr_c%0d", nm, cyc), tile_addr, (cyc < N) ? cyc : N - 1);
                check($sformatf("%s_busy_c%0d", nm, cyc), busy, 1);
            end
            if (cyc == N + 2) check({nm, "_hold_prev"}, coll_flags, last_exp);
            @(negedge clk);
            cyc++;
        end
        check({nm, "_done_cycle"}, cyc, N + 3);
        check({nm, "_flags"}, coll_flags, exp);
        check({nm, "_busy_in_done"}, busy, 1);
        last_exp = exp;
        @(negedge clk);
        check({nm, "_done_pulse"}, done, 0);
        check({nm, "_busy_off"}, busy, 0);
    endtask

    initial begin
        int cyc;
        int ndone;
        int dcyc;
        int dq[$];
        logic [9:0] xr;
        logic [3:0] e;

        start    = 1'b0;
        x_blue   = 10'd100;
        y_blue   = 9'd50;
        last_exp = 4'b0000;
        load('0, '0);

        vecs[0] = '{v: 4'b1111, f: 16'h0100, exp: 4'b0001};
        vecs[1] = '{v: 4'b1110, f: 16'h4083, exp: 4'b1100};
        vecs[2] = '{v: 4'b1111, f: 16'h8421, exp: 4'b1111};
        vecs[3] = '{v: 4'b0000, f: 16'hFFFF, exp: 4'b0000};
        vecs[4] = '{v: 4'b1111, f: 16'h0020, exp: 4'b0010};
        vecs[5] = '{v: 4'b1111, f: 16'h0000, exp: 4'b0000};
        vecs[6] = '{v: 4'b0101, f: 16'h1248, exp: 4'b1010};

        repeat (2) @(negedge clk);
        check("rst_addr", tile_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_flags", coll_flags, 0);
        check("rst_xblue", chk_x_blue, 0);
        check("rst_yblue", chk_y_blue, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].v, vecs[i].f);
            xr     = 10'($urandom_range(0, 1023));
            x_blue = xr;
            y_blue = 9'($urandom_range(0, 511));
            run_scan(vecs[i].exp, $sformatf("vec%0d", i), i == 0);
            check($sformatf("vec%0d_xlatch", i), chk_x_blue, xr);
        end

        for (int r = 0; r < 12; r++) begin
            load(N'($urandom), 16'($urandom));
            run_scan(model_or(), $sformatf("rand%0d", r), 1'b0);
        end

        // player x changes mid-scan and start pulses while busy
        load(4'b1111, 16'h1000);
        e      = model_or();
        x_blue = 10'd100;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        ndone = 0;
        dcyc  = -1;
        repeat (18) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) x_blue = 10'd200;
            start = (cyc == 3 || cyc == 5);
            if (done) begin
                ndone++;
                dcyc = cyc;
                check("xchg_flags", coll_flags, e);
                check("xchg_xlatch_done", chk_x_blue, 100);
            end
        end
        check("xchg_ndone", ndone, 1);
        check("xchg_done_cycle", dcyc, N + 3);
        check("xchg_xlatch_after", chk_x_blue, 100);
        last_exp = e;
        run_scan(e, "xnext", 1'b0);
        check("xnext_xlatch", chk_x_blue, 200);

        // start held high: one scan per N+4 cycles
        load(4'b1011, 16'h3C5A);
        e     = model_or();
        start = 1'b1;
        cyc   = -1;
        repeat (32) begin
            @(negedge clk);
            cyc++;
            if (done) dq.push_back(cyc);
        end
        start = 1'b0;
        check("held_ndone", dq.size(), 4);
        for (int k = 0; k < dq.size(); k++) begin
            check($sformatf("held_done%0d", k), dq[k], 7 + 8 * k);
        end
        check("held_flags", coll_flags, e);
        last_exp = e;
        @(negedge clk);
        check("held_idle", busy, 0);

        // asynchronous reset in the middle of ISSUE
        load(4'b1111, 16'h8421);
        run_scan(4'b1111, "prerst", 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_addr_before", tile_addr, 2);
        #2 rst = 1'b1;
        #1;
        check("arst_addr", tile_addr, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_flags", coll_flags, 0);
        check("arst_xblue", chk_x_blue, 0);
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("arst_no_done", ndone, 0);
        last_exp = 4'b0000;
        load(4'b0110, 16'h0420);
        run_scan(4'b0110, "postrst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
